conv_sched: RTL and testbench
=============================

# conv_sched

Sequencing controller for the 2-layer image engine: walks a 64×64 input image pixel by pixel, issues the nine 3×3-window image fetches with zero-padding flags, and drives MAC-datapath control. It then writes each convolution result to layer-0 memory and, optionally, runs a 2×2 max-pool pass from layer 0 into layer 1. It owns every address, strobe and memory-select line; arithmetic is done by the external MAC/pool datapath.

## Interface

- `IMG_W`, 64, image width/height; power of two, at least 4.
- `AW`, 12, address width; equals log2(`IMG_W`²).
- `clk` in 1, sole clock, rising edge.
- `reset` in 1, synchronous, active-low; 0 = reset.
- `ready` in 1, start request, sampled in IDLE only.
- `busy` out 1, high from start until the final write completes.
- `iaddr` out AW, image read address.
- `mac_clr` out 1, clear the accumulator before the first tap of a pixel.
- `mac_en` out 1, accumulate `idata`×kernel[`mac_tap`].
- `mac_tap` out 4, kernel index 0–8, aligned with `mac_en`.
- `mac_zero` out 1, padded tap; the datapath substitutes 0 for `idata`. Aligned with `mac_en`.
- `pool_clr` out 1, reset the running maximum.
- `pool_en` out 1, compare `cdata_rd` into the running maximum.
- `wr_src` out 1, 0 = conv result, 1 = pool maximum onto `cdata_wr`.
- `cwr` out 1, layer-memory write strobe.
- `caddr_wr` out AW, write address.
- `crd` out 1, layer-memory read strobe.
- `caddr_rd` out AW, read address.
- `csel` out 3, memory select: 000 none, 001 layer 0, 011 layer 1.

## Operation

- **States:** IDLE, FETCH, DRAIN, WR0, PRD, PDRAIN, WR1, DONE.
- **IDLE:**
  - `ready`=1 moves the block to FETCH with x=y=0 and tap=0, and sets `busy`=1.
- **FETCH:**
  - The block stays for 9 cycles, tap t=0..8.
  - Window offsets are dy=t/3−1 and dx=t%3−1.
  - A tap is padded when y+dy or x+dx lies outside [0, `IMG_W`−1].
  - `iaddr` = (y+dy)·`IMG_W`+(x+dx), or 0 when the tap is padded.
  - `mac_clr`=1 in the t=0 cycle.
- **Data alignment:**
  - `idata` is valid one cycle after `iaddr`.
  - `mac_en`, `mac_tap` and `mac_zero` are therefore the FETCH signals registered once: `mac_en` is high for 9 consecutive cycles, starting one cycle after t=0.
- **DRAIN:** one cycle, covering the last `mac_en`.
- **WR0:**
  - Drives `cwr`=1, `csel`=001, `wr_src`=0 and `caddr_wr`=y·`IMG_W`+x.
  - x increments, wrapping at `IMG_W`−1 with y incrementing.
  - After pixel (`IMG_W`−1, `IMG_W`−1) the block goes to PRD if pooling is enabled, otherwise to DONE; in all other cases it returns to FETCH.
  - Each pixel takes 11 cycles.
- **PRD:**
  - Block (bx, by) spans 0..`IMG_W`/2−1.
  - The block issues 4 reads with `crd`=1 and `csel`=001, at addresses in the order (2by, 2bx), (2by, 2bx+1), (2by+1, 2bx), (2by+1, 2bx+1).
  - `pool_clr`=1 with the first read.
  - `pool_en` is `crd` delayed one cycle.
- **PDRAIN:** one cycle.
- **WR1:**
  - Drives `cwr`=1, `csel`=011, `wr_src`=1 and `caddr_wr`=by·(`IMG_W`/2)+bx.
  - The last block goes to DONE; otherwise the block returns to PRD.
  - Each pool block takes 6 cycles.
- **DONE:**
  - `busy`=0 and all strobes are 0; the block holds until reset.
  - `ready` is ignored in every state except IDLE.

## Timing

- **Reset values:** all outputs 0, `csel`=000, state IDLE, counters 0.
- **Reset mid-operation:** a 0 on `reset` at any edge aborts the pass. On that edge all outputs return to their reset values and the state becomes IDLE. A partially written layer is not cleaned up.
- **Start latency:** `ready` sampled at edge E gives `busy`=1 and the first `iaddr` (t=0) after E.
- **Strobe width:** `cwr` and `crd` are single-cycle.
- **No read/write overlap:** `cwr` and `crd` are never high in the same cycle.
- **Idle `csel`:** 000 whenever neither strobe is high.
- **`busy` fall:** the cycle after the final WR0 (pooling off) or final WR1 (pooling on).
- **Total cycles (IMG_W=64):** 4096·11 = 45056 for convolution, plus 1024·6 = 6144 for pooling.
- **Edge pixels:** corner pixels pad 5 taps; non-corner edge pixels pad 3.
- **Wrap-around:** counter wrap never produces an address ≥ `IMG_W`².

## Configuration

- `CONV_POOL_EN`
  - **Defined:** PRD/PDRAIN/WR1 are compiled in; the layer-1 max-pool pass follows convolution.
  - **Undefined:**
    - WR0 of the last pixel goes straight to DONE.
    - `pool_clr`, `pool_en` and `wr_src` are tied to 0.
    - `csel`=011 never occurs.

## Test plan

- **Reset:**
  - Stimulus: hold `reset`=0 for 3 cycles with `ready`=1.
  - Response: every output is 0, `csel`=000 and `busy`=0.
  - After release: `busy`=1 one cycle after `ready` is sampled.
- **Pixel (0,0):**
  - `iaddr` sequence is 0,0,0,0,0,1,0,64,65.
  - `mac_zero` sequence is 1,1,1,1,0,0,1,0,0.
  - WR0 has `caddr_wr`=0 and `csel`=001.
- **Interior pixel (1,1):**
  - `iaddr` sequence is 0,1,2,64,65,66,128,129,130, with `mac_zero` all 0.
  - `caddr_wr`=65.
  - WR0 occurs exactly 11 cycles after the previous WR0.
- **Pool block (0,0), `CONV_POOL_EN` defined:**
  - `caddr_rd` sequence is 0,1,64,65 with `pool_en` lagging by 1 cycle.
  - WR1 has `caddr_wr`=0 and `csel`=011.
  - Last block writes `caddr_wr`=1023; `busy` falls 51200 cycles after start.
- **Reset mid-pass:**
  - Stimulus: assert `reset`=0 during FETCH of pixel 100.
  - Response: IDLE and all-zero outputs after that edge.
  - A new `ready` restarts the pass at pixel (0,0).
- **Macro undefined, `ready` pulsed while busy:**
  - The second `ready` pulse has no effect.
  - `busy` falls after WR0 with `caddr_wr`=4095, 45056 cycles after start.
  - `csel`=011 is never seen.

Source files
------------

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - 3x3 convolution / 2x2 max-pool address and strobe sequencer
// Optional layer-1 max-pool pass compiled in when CONV_POOL_EN is defined.
module conv_sched #(
    parameter int IMG_W = 64,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic [AW-1:0] iaddr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [3:0]    mac_tap,
    output logic          mac_zero,
    output logic          pool_clr,
    output logic          pool_en,
    output logic          wr_src,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    output logic [2:0]    csel
);

    localparam int XW = AW / 2;
    localparam logic [XW-1:0] LAST = XW'(IMG_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_WR0    = 3'd3;
`ifdef CONV_POOL_EN
    localparam logic [2:0] S_PRD    = 3'd4;
    localparam logic [2:0] S_PDRAIN = 3'd5;
    localparam logic [2:0] S_WR1    = 3'd6;
    localparam logic [XW-2:0] BLAST = (XW-1)'(IMG_W / 2 - 1);
`endif
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]    r_state;
    logic [XW-1:0] r_x;
    logic [XW-1:0] r_y;
    logic [3:0]    r_tap;
    logic          r_mac_en;
    logic [3:0]    r_mac_tap;
    logic          r_mac_zero;

    logic [1:0]    w_row;
    logic [1:0]    w_col;
    logic          w_pad;
    logic [XW-1:0] w_yy;
    logic [XW-1:0] w_xx;
    logic          w_fetch;
    logic          w_wr0;

    assign w_fetch = (r_state == S_FETCH);
    assign w_wr0   = (r_state == S_WR0);

    // Window position of the current tap: row = dy+1, col = dx+1.
    always_comb begin
        w_row = 2'd0;
        w_col = 2'd0;
        case (r_tap)
            4'd0:    begin w_row = 2'd0; w_col = 2'd0; end
            4'd1:    begin w_row = 2'd0; w_col = 2'd1; end
            4'd2:    begin w_row = 2'd0; w_col = 2'd2; end
            4'd3:    begin w_row = 2'd1; w_col = 2'd0; end
            4'd4:    begin w_row = 2'd1; w_col = 2'd1; end
            4'd5:    begin w_row = 2'd1; w_col = 2'd2; end
            4'd6:    begin w_row = 2'd2; w_col = 2'd0; end
            4'd7:    begin w_row = 2'd2; w_col = 2'd1; end
            4'd8:    begin w_row = 2'd2; w_col = 2'd2; end
            default: begin w_row = 2'd1; w_col = 2'd1; end
        endcase
    end

    assign w_pad = (w_row == 2'd0 && r_y == '0) || (w_row == 2'd2 && r_y == LAST) ||
                   (w_col == 2'd0 && r_x == '0) || (w_col == 2'd2 && r_x == LAST);
    assign w_yy  = r_y + XW'(w_row) - XW'(1);
    assign w_xx  = r_x + XW'(w_col) - XW'(1);

    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign iaddr    = (w_fetch && !w_pad) ? {w_yy, w_xx} : '0;
    assign mac_clr  = w_fetch && (r_tap == 4'd0);
    assign mac_en   = r_mac_en;
    assign mac_tap  = r_mac_tap;
    assign mac_zero = r_mac_zero;

`ifdef CONV_POOL_EN
    logic [XW-2:0] r_bx;
    logic [XW-2:0] r_by;
    logic [1:0]    r_rd;
    logic          r_pool_en;
    logic          w_wr1;

    assign w_wr1    = (r_state == S_WR1);
    assign crd      = (r_state == S_PRD);
    assign caddr_rd = crd ? {r_by, r_rd[1], r_bx, r_rd[0]} : '0;
    assign pool_clr = crd && (r_rd == 2'd0);
    assign pool_en  = r_pool_en;
    assign wr_src   = w_wr1;
    assign cwr      = w_wr0 || w_wr1;
    assign caddr_wr = w_wr0 ? {r_y, r_x} : (w_wr1 ? {2'b00, r_by, r_bx} : '0);
    assign csel     = w_wr1 ? 3'b011 : ((w_wr0 || crd) ? 3'b001 : 3'b000);
`else
    assign crd      = 1'b0;
    assign caddr_rd = '0;
    assign pool_clr = 1'b0;
    assign pool_en  = 1'b0;
    assign wr_src   = 1'b0;
    assign cwr      = w_wr0;
    assign caddr_wr = w_wr0 ? {r_y, r_x} : '0;
    assign csel     = w_wr0 ? 3'b001 : 3'b000;
`endif

    // idata lags iaddr by one cycle, so the MAC controls are the fetch view registered once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mac_en   <= 1'b0;
            r_mac_tap  <= 4'd0;
            r_mac_zero <= 1'b0;
        end else begin
            r_mac_en   <= w_fetch;
            r_mac_tap  <= w_fetch ? r_tap : 4'd0;
            r_mac_zero <= w_fetch && w_pad;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_tap   <= 4'd0;
`ifdef CONV_POOL_EN
            r_bx      <= '0;
            r_by      <= '0;
            r_rd      <= 2'd0;
            r_pool_en <= 1'b0;
`endif
        end else begin
`ifdef CONV_POOL_EN
            r_pool_en <= crd;
`endif
            case (r_state)
                S_IDLE: begin
                    if (ready) begin
                        r_state <= S_FETCH;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_tap   <= 4'd0;
                    end
                end
                S_FETCH: begin
                    if (r_tap == 4'd8) begin
                        r_tap   <= 4'd0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_tap <= r_tap + 4'd1;
                    end
                end
                S_DRAIN: r_state <= S_WR0;
                S_WR0: begin
                    r_state <= S_FETCH;
                    if (r_x == LAST) begin
                        r_x <= '0;
                        if (r_y == LAST) begin
`ifdef CONV_POOL_EN
                            r_state <= S_PRD;
                            r_bx    <= '0;
                            r_by    <= '0;
                            r_rd    <= 2'd0;
`else
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_y <= r_y + XW'(1);
                        end
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
`ifdef CONV_POOL_EN
                S_PRD: begin
                    r_rd <= r_rd + 2'd1;
                    if (r_rd == 2'd3)
                        r_state <= S_PDRAIN;
                end
                S_PDRAIN: r_state <= S_WR1;
                S_WR1: begin
                    r_state <= S_PRD;
                    if (r_bx == BLAST) begin
                        r_bx <= '0;
                        if (r_by == BLAST)
                            r_state <= S_DONE;
                        else
                            r_by <= r_by + (XW-1)'(1);
                    end else begin
                        r_bx <= r_bx + (XW-1)'(1);
                    end
                end
`endif
                S_DONE:  r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - self-checking bench for conv_sched against a cycle-indexed reference model
module tb_conv_sched;

    localparam int W    = 64;
    localparam int CONV = W * W * 11;
`ifdef CONV_POOL_EN
    localparam int POOL = (W / 2) * (W / 2) * 6;
`else
    localparam int POOL = 0;
`endif
    localparam int TOTAL = CONV + POOL;

    typedef struct packed {
        logic        busy;
        logic [11:0] iaddr;
        logic        mac_clr;
        logic        mac_en;
        logic [3:0]  mac_tap;
        logic        mac_zero;
        logic        pool_clr;
        logic        pool_en;
        logic        wr_src;
        logic        cwr;
        logic [11:0] caddr_wr;
        logic        crd;
        logic [11:0] caddr_rd;
        logic [2:0]  csel;
    } out_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic        mac_clr;
    logic        mac_en;
    logic [3:0]  mac_tap;
    logic        mac_zero;
    logic        pool_clr;
    logic        pool_en;
    logic        wr_src;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [2:0]  csel;

    int n_cmp  = 0;
    int n_fail = 0;

    conv_sched #(.IMG_W(W), .AW(12)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_tap(mac_tap), .mac_zero(mac_zero),
        .pool_clr(pool_clr), .pool_en(pool_en), .wr_src(wr_src), .cwr(cwr),
        .caddr_wr(caddr_wr), .crd(crd), .caddr_rd(caddr_rd), .csel(csel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t obs();
        out_t o;
        o.busy = busy; o.iaddr = iaddr; o.mac_clr = mac_clr; o.mac_en = mac_en;
        o.mac_tap = mac_tap; o.mac_zero = mac_zero; o.pool_clr = pool_clr;
        o.pool_en = pool_en; o.wr_src = wr_src; o.cwr = cwr; o.caddr_wr = caddr_wr;
        o.crd = crd; o.caddr_rd = caddr_rd; o.csel = csel;
        return o;
    endfunction

    function automatic bit tap_pad(int x, int y, int t);
        int yy = y + t / 3 - 1;
        int xx = x + t % 3 - 1;
        return (yy < 0) || (yy >= W) || (xx < 0) || (xx >= W);
    endfunction

    function automatic int tap_addr(int x, int y, int t);
        if (tap_pad(x, y, t)) return 0;
        return (y + t / 3 - 1) * W + (x + t % 3 - 1);
    endfunction

    // Expected outputs k cycles after start (k<0: idle/reset, k>=TOTAL: done); m marks the bits that matter.
    function automatic void model(input int k, output out_t e, output out_t m);
        e = '0;
        m = '1;
        if (k < 0) return;
        if (k >= TOTAL) begin
            m = '0;
            m.busy = 1'b1; m.mac_clr = 1'b1; m.mac_en = 1'b1; m.pool_clr = 1'b1;
            m.pool_en = 1'b1; m.cwr = 1'b1; m.crd = 1'b1; m.csel = '1;
            return;
        end
        e.busy = 1'b1;
        if (k < CONV) begin
            int p = k / 11, ph = k % 11;
            int x = p % W, y = p / W;
            m.caddr_rd = '0;
            if (ph <= 8) begin
                e.iaddr   = 12'(tap_addr(x, y, ph));
                e.mac_clr = (ph == 0);
            end else m.iaddr = '0;
            if (ph >= 1 && ph <= 9) begin
                e.mac_en   = 1'b1;
                e.mac_tap  = 4'(ph - 1);
                e.mac_zero = tap_pad(x, y, ph - 1);
            end else begin
                m.mac_tap = '0; m.mac_zero = 1'b0;
            end
            if (ph == 10) begin
                e.cwr = 1'b1; e.csel = 3'b001; e.caddr_wr = 12'(y * W + x);
            end else begin
                m.caddr_wr = '0; m.wr_src = 1'b0;
            end
        end else begin
            int q = k - CONV, b = q / 6, ph = q % 6;
            int bx = b % (W / 2), by = b / (W / 2);
            m.iaddr = '0; m.mac_tap = '0; m.mac_zero = 1'b0;
            if (ph <= 3) begin
                e.crd = 1'b1; e.csel = 3'b001; e.pool_clr = (ph == 0);
                e.caddr_rd = 12'((2 * by + ph / 2) * W + 2 * bx + ph % 2);
            end else m.caddr_rd = '0;
            e.pool_en = (ph >= 1 && ph <= 4);
            if (ph == 5) begin
                e.cwr = 1'b1; e.csel = 3'b011; e.wr_src = 1'b1;
                e.caddr_wr = 12'(by * (W / 2) + bx);
            end else begin
                m.caddr_wr = '0; m.wr_src = 1'b0;
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        out_t o, e, m;
        reset = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = obs();
            n_cmp++;
            if (o !== out_t'(0)) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h want %h", i, o, out_t'(0));
            end
        end
        reset = 1'b1;
        tick();
        ready = 1'b0;
        o = obs();
        model(0, e, m);
        n_cmp++;
        if ((o & m) !== (e & m)) begin
            n_fail++;
            $display("FAIL reset_release_start: got %h want %h", o & m, e & m);
        end
        do_reset();
    endtask

    task automatic test_pixel_sequences();
        int ia0[9], z0[9], ia11[9], z11[9];
        int exp_ia0[9]  = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
        int exp_z0[9]   = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
        int exp_ia11[9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
        int wa0 = -1, cs0 = -1, wa11 = -1, prev_wr = -1, gap = -1;
        repeat ($urandom_range(1, 4)) tick();
        ready = 1'b1;
        for (int k = 0; k <= 726; k++) begin
            tick();
            ready = 1'b0;
            if (k <= 8) ia0[k] = int'(iaddr);
            if (k >= 1 && k <= 9) z0[k - 1] = int'(mac_zero);
            if (k == 10) begin wa0 = int'(caddr_wr); cs0 = int'(csel); end
            if (k >= 715 && k <= 723) ia11[k - 715] = int'(iaddr);
            if (k >= 716 && k <= 724) z11[k - 716] = int'(mac_zero);
            if (k == 725) wa11 = int'(caddr_wr);
            if (cwr === 1'b1) begin
                if (prev_wr >= 0) gap = k - prev_wr;
                prev_wr = k;
            end
        end
        for (int i = 0; i < 9; i++) begin
            n_cmp += 4;
            if (ia0[i] !== exp_ia0[i]) begin
                n_fail++; $display("FAIL pix00_iaddr t=%0d: got %0d want %0d", i, ia0[i], exp_ia0[i]);
            end
            if (z0[i] !== exp_z0[i]) begin
                n_fail++; $display("FAIL pix00_zero t=%0d: got %0d want %0d", i, z0[i], exp_z0[i]);
            end
            if (ia11[i] !== exp_ia11[i]) begin
                n_fail++; $display("FAIL pix11_iaddr t=%0d: got %0d want %0d", i, ia11[i], exp_ia11[i]);
            end
            if (z11[i] !== 0) begin
                n_fail++; $display("FAIL pix11_zero t=%0d: got %0d want 0", i, z11[i]);
            end
        end
        n_cmp += 4;
        if (wa0 !== 0) begin n_fail++; $display("FAIL pix00_caddr_wr: got %0d want 0", wa0); end
        if (cs0 !== 1) begin n_fail++; $display("FAIL pix00_csel: got %0d want 1", cs0); end
        if (wa11 !== 65) begin n_fail++; $display("FAIL pix11_caddr_wr: got %0d want 65", wa11); end
        if (gap !== 11) begin n_fail++; $display("FAIL wr0_spacing: got %0d want 11", gap); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        out_t o, e, m;
        int stop_k = 100 * 11 + $urandom_range(0, 8);
        ready = 1'b1;
        for (int k = 0; k <= stop_k; k++) begin
            tick();
            ready = 1'($urandom_range(0, 1));
        end
        n_cmp++;
        if (busy !== 1'b1 || mac_en !== (stop_k != 1100)) begin
            n_fail++;
            $display("FAIL mid_fetch_state: got busy=%b mac_en=%b want busy=1 mac_en=%b", busy, mac_en, stop_k != 1100);
        end
        reset = 1'b0;
        ready = 1'b1;
        tick();
        o = obs();
        n_cmp++;
        if (o !== out_t'(0)) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h want %h", o, out_t'(0));
        end
        reset = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            ready = 1'b0;
            o = obs();
            model(k, e, m);
            n_cmp++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL restart_cycle %0d: got %h want %h", k, o & m, e & m);
            end
        end
        do_reset();
    endtask

    task automatic test_full_pass();
        out_t o, e, m;
        int busy_cnt = 0, csel3 = 0, last_wr = -1, local_fail = 0;
`ifdef CONV_POOL_EN
        int rd0[4], pe0[4];
        int exp_rd0[4] = '{0, 1, 64, 65};
`endif
        repeat ($urandom_range(1, 5)) tick();
        ready = 1'b1;
        for (int k = 0; k < TOTAL + 8; k++) begin
            tick();
            ready = 1'($urandom_range(0, 1));
            o = obs();
            model(k, e, m);
            n_cmp++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                local_fail++;
                $display("FAIL pass_cycle %0d: got %h want %h", k, o & m, e & m);
                if (local_fail > 20) break;
            end
            if (o.busy === 1'b1) busy_cnt++;
            if (o.csel === 3'b011) csel3++;
            if (o.cwr === 1'b1) last_wr = int'(o.caddr_wr);
`ifdef CONV_POOL_EN
            if (k >= CONV && k < CONV + 4) rd0[k - CONV] = int'(o.caddr_rd);
            if (k >= CONV + 1 && k < CONV + 5) pe0[k - CONV - 1] = int'(o.pool_en);
`endif
        end
`ifdef CONV_POOL_EN
        for (int i = 0; i < 4; i++) begin
            n_cmp += 2;
            if (rd0[i] !== exp_rd0[i]) begin
                n_fail++; $display("FAIL pool0_caddr_rd %0d: got %0d want %0d", i, rd0[i], exp_rd0[i]);
            end
            if (pe0[i] !== 1) begin
                n_fail++; $display("FAIL pool0_pool_en %0d: got %0d want 1", i, pe0[i]);
            end
        end
        n_cmp += 2;
        if (busy_cnt !== 51200) begin n_fail++; $display("FAIL busy_cycles: got %0d want 51200", busy_cnt); end
        if (last_wr !== 1023) begin n_fail++; $display("FAIL last_caddr_wr: got %0d want 1023", last_wr); end
`else
        n_cmp += 3;
        if (busy_cnt !== 45056) begin n_fail++; $display("FAIL busy_cycles: got %0d want 45056", busy_cnt); end
        if (last_wr !== 4095) begin n_fail++; $display("FAIL last_caddr_wr: got %0d want 4095", last_wr); end
        if (csel3 !== 0) begin n_fail++; $display("FAIL csel_011_seen: got %0d want 0", csel3); end
`endif
        do_reset();
    endtask

    initial begin
        reset = 1'b0;
        ready = 1'b0;
        test_reset();
        test_pixel_sequences();
        test_reset_mid();
        test_full_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
